// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, one 4-bit nibble per clock using
// borrow-lookahead logic, with valid/ready handshakes on both sides.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d, diff_new;
  logic              brw_q, brw_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              b_out_q, b_out_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [3:0] a_nib, b_nib, g, p, nib_diff;
  logic [4:0] br;
  logic       accept;

  assign accept = in_valid & in_ready_q & (state_q == IDLE);

  // State register (all flops).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      brw_q       <= 1'b0;
      idx_q       <= '0;
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      brw_q       <= brw_d;
      idx_q       <= idx_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered so they follow the state register exactly.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Borrow-lookahead for the current nibble.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    g     = ~a_nib & b_nib;
    p     = ~(a_nib ^ b_nib);
    br[0] = brw_q;
    br[1] = g[0] | (p[0] & brw_q);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & brw_q);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & brw_q);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & brw_q);
    nib_diff = a_nib ^ b_nib ^ br[3:0];
    diff_new = diff_q;
    diff_new[{idx_q, 2'b00} +: 4] = nib_diff;
  end

  // Datapath updates.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    idx_d   = idx_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = a;
          b_d    = b;
          brw_d  = b_in;
          idx_d  = '0;
          diff_d = '0;
        end
      end
      CALC: begin
        diff_d = diff_new;
        brw_d  = br[4];
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          b_out_d = br[4];
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_new[WIDTH-1]);
          zero_d  = (diff_new == '0);
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16) with a result scoreboard.
module tb_nibble_serial_subtractor;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, b_in, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         b_out, ovf, zero;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    logic [W:0] r;
    exp_t e;
    r    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ r[W-1]);
    e.z  = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, check latency, optional backpressure and the result.
  // poke keeps in_valid high after acceptance to verify it is ignored.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input int hold, input bit poke);
    int   n;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; b_in = bi; in_valid = 1'b1;
    sb.push_back(model(av, bv, bi));
    tick();
    in_valid = poke;
    a = ~av; b = ~bv; b_in = ~bi;
    for (int c = 1; c <= NIB; c++) begin
      check("calc_in_ready", {31'd0, in_ready}, 32'd0);
      check("latency_valid", {31'd0, out_valid}, 32'd0);
      if (c < NIB) tick();
    end
    tick();
    check("done_valid", {31'd0, out_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_diff", {16'd0, diff}, {16'd0, sb[0].d});
      check("hold_flags", {29'd0, b_out, ovf, zero}, {29'd0, sb[0].bo, sb[0].ov, sb[0].z});
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("diff", {16'd0, diff}, {16'd0, e.d});
      check("b_out", {31'd0, b_out}, {31'd0, e.bo});
      check("ovf", {31'd0, ovf}, {31'd0, e.ov});
      check("zero", {31'd0, zero}, {31'd0, e.z});
      $display("op a=%04h b=%04h b_in=%0d -> diff=%04h b_out=%0d ovf=%0d zero=%0d",
               av, bv, bi, diff, b_out, ovf, zero);
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_diff_kept", {16'd0, diff}, {16'd0, e.d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_flags", {29'd0, b_out, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1, 1'b0);
    run_op(16'h0010, 16'h000F, 1'b1, 0, 1'b1);
    run_op(16'h5555, 16'h1111, 1'b0, 5, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), i, 1'(i));
    end

    // Reset during the second CALC cycle abandons the operation.
    a = 16'h1234; b = 16'h1111; b_in = 1'b0; in_valid = 1'b1;
    check("mid_rst_accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_diff", {16'd0, diff}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_flags", {29'd0, b_out, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_release_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
